// File: rtl/arf054b256e1r1w0cbbeheaa4acw_pkg.sv
// Shared constants and types for the read-output stage of the 256x54 1R1W register file.
package arf054b256e1r1w0cbbeheaa4acw_pkg;

  localparam int DWIDTH    = 54;
  localparam int AWIDTH    = 8;
  localparam int RSP_DEPTH = 3;

  typedef logic [1:0] count_t;
  typedef logic [1:0] ptr_t;

  // Pointers cycle through 0..RSP_DEPTH-1 and wrap from 2 back to 0.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(RSP_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_rd_out_stage_if.sv
// Request, array, write-bypass and response signals of the read-output stage.
interface arf054b256e1r1w0cbbeheaa4acw_rd_out_stage_if #(
  parameter int DWIDTH = arf054b256e1r1w0cbbeheaa4acw_pkg::DWIDTH,
  parameter int AWIDTH = arf054b256e1r1w0cbbeheaa4acw_pkg::AWIDTH
);
  // Handshakes: a beat transfers on a clock edge where vld and rdy are both 1;
  // vld never depends on rdy, and an offered response holds until taken.
  logic              rd_req_vld;
  logic              rd_req_rdy;
  logic [AWIDTH-1:0] rd_req_adr;
  logic              arr_rd_en;
  logic [AWIDTH-1:0] arr_rd_adr;
  logic [DWIDTH-1:0] arr_rd_dat;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_adr;
  logic [DWIDTH-1:0] wr_dat;
  logic              rd_rsp_vld;
  logic              rd_rsp_rdy;
  logic [DWIDTH-1:0] rd_rsp_dat;

  modport slave (
    input  rd_req_vld, rd_req_adr, arr_rd_dat, wr_en, wr_adr, wr_dat, rd_rsp_rdy,
    output rd_req_rdy, arr_rd_en, arr_rd_adr, rd_rsp_vld, rd_rsp_dat
  );

  modport master (
    output rd_req_vld, rd_req_adr, arr_rd_dat, wr_en, wr_adr, wr_dat, rd_rsp_rdy,
    input  rd_req_rdy, arr_rd_en, arr_rd_adr, rd_rsp_vld, rd_rsp_dat
  );
endinterface

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_rd_rsp_fifo.sv
// Three-entry response FIFO; control state is reset, the data storage is not.
module arf054b256e1r1w0cbbeheaa4acw_rd_rsp_fifo
  import arf054b256e1r1w0cbbeheaa4acw_pkg::*;
#(
  parameter int DWIDTH = arf054b256e1r1w0cbbeheaa4acw_pkg::DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_dat_i,
  input  logic              pop_i,
  output logic              vld_o,
  output logic [DWIDTH-1:0] dat_o,
  output count_t            count_o
);

  logic [DWIDTH-1:0] mem_q [RSP_DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  count_t            count_q, count_d;
  logic              do_pop;

  assign do_pop = pop_i && (count_q != count_t'(0));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign vld_o   = (count_q != count_t'(0));
  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The upstream credit check leaves room for every push.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst) !(push_i && (count_q == count_t'(RSP_DEPTH)))
  );

endmodule

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_rd_out_stage.sv
// Read-output stage: issues the array read, bypasses a same-cycle write, buffers responses.
module arf054b256e1r1w0cbbeheaa4acw_rd_out_stage
  import arf054b256e1r1w0cbbeheaa4acw_pkg::*;
#(
  parameter int DWIDTH = arf054b256e1r1w0cbbeheaa4acw_pkg::DWIDTH,
  parameter int AWIDTH = arf054b256e1r1w0cbbeheaa4acw_pkg::AWIDTH
) (
  input  logic clk,
  input  logic rst,
  arf054b256e1r1w0cbbeheaa4acw_rd_out_stage_if.slave bus
);

  logic              accept;
  logic              pop;
  logic [AWIDTH-1:0] req_adr;
  logic [2:0]        occupancy;

  logic              p1_vld_q, p1_vld_d;
  logic              p1_hit_q, p1_hit_d;
  logic [DWIDTH-1:0] p1_dat_q, p1_dat_d;

  logic [DWIDTH-1:0] push_dat;
  count_t            fifo_count;
  logic              fifo_vld;
  logic [DWIDTH-1:0] fifo_dat;

  // Credit counts both buffered and in-flight responses, so it never sees rd_rsp_rdy.
  assign req_adr        = bus.rd_req_adr;
  assign occupancy      = {1'b0, fifo_count} + {2'b00, p1_vld_q};
  assign bus.rd_req_rdy = rst && (occupancy < 3'(RSP_DEPTH));
  assign accept         = bus.rd_req_vld && bus.rd_req_rdy;
  assign bus.arr_rd_en  = accept;
  assign bus.arr_rd_adr = req_adr;

  always_comb begin
    p1_vld_d = accept;
    p1_hit_d = bus.wr_en && (bus.wr_adr == req_adr);
    p1_dat_d = bus.wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_vld_q <= 1'b0;
      p1_hit_q <= 1'b0;
    end else begin
      p1_vld_q <= p1_vld_d;
      p1_hit_q <= p1_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    p1_dat_q <= p1_dat_d;
  end

  // The array returns the pre-write value, so a same-cycle write wins.
  assign push_dat = p1_hit_q ? p1_dat_q : bus.arr_rd_dat;

  arf054b256e1r1w0cbbeheaa4acw_rd_rsp_fifo #(
    .DWIDTH (DWIDTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (p1_vld_q),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .vld_o      (fifo_vld),
    .dat_o      (fifo_dat),
    .count_o    (fifo_count)
  );

  assign bus.rd_rsp_vld = rst && fifo_vld;
  assign bus.rd_rsp_dat = bus.rd_rsp_vld ? fifo_dat : '0;
  assign pop            = bus.rd_rsp_vld && bus.rd_rsp_rdy;

endmodule
